// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter (LSB first, idle high).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 4167,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clock,
   input  logic                          resetb,
   input  logic                          wr_valid,
   input  logic [7:0]                    wr_data,
   output logic                          wr_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow
);
   localparam int              AW       = $clog2(FIFO_DEPTH);
   localparam int              LW       = AW + 1;
   localparam logic [15:0]     BIT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [LW-1:0]   LVL_FULL = LW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t          r_state, w_state_next;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]   r_level;
   logic            r_overflow;
   logic            r_tx, w_tx_next;
   logic [15:0]     r_clk_cnt, w_cnt_next;
   logic [2:0]      r_bit_cnt, w_bit_next;
   logic [7:0]      r_shift;
`ifdef UART_TX_PARITY_EN
   logic            r_parity;
`endif
   logic            w_push, w_pop, w_shift_adv, w_bit_end, w_nonempty;
   logic [7:0]      w_head;

   // wr_ready depends only on registered occupancy, never on wr_valid
   assign wr_ready   = (r_level != LVL_FULL);
   assign w_push     = wr_valid & wr_ready & resetb;
   assign w_nonempty = (r_level != '0);
   assign w_bit_end  = (r_clk_cnt == BIT_LAST);
   assign w_head     = r_mem[r_rd_ptr];

   assign tx       = r_tx;
   assign level    = r_level;
   assign overflow = r_overflow;
   assign busy     = (r_state != S_IDLE) | w_nonempty;

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_tx_next    = r_tx;
      w_cnt_next   = r_clk_cnt + 16'd1;
      w_bit_next   = r_bit_cnt;
      w_shift_adv  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_next = '0;
            w_bit_next = '0;
            w_tx_next  = 1'b1;
            if (w_nonempty) begin
               w_pop        = 1'b1;
               w_state_next = S_START;
               w_tx_next    = 1'b0;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_cnt_next   = '0;
               w_bit_next   = '0;
               w_state_next = S_DATA;
               w_tx_next    = r_shift[0];
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_cnt_next = '0;
               if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_next = S_PARITY;
                  w_tx_next    = r_parity;
`else
                  w_state_next = S_STOP;
                  w_tx_next    = 1'b1;
`endif
               end else begin
                  w_bit_next  = r_bit_cnt + 3'd1;
                  w_shift_adv = 1'b1;
                  w_tx_next   = r_shift[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_bit_end) begin
               w_cnt_next   = '0;
               w_state_next = S_STOP;
               w_tx_next    = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (w_bit_end) begin
               w_cnt_next = '0;
               // chain straight into the next start bit when data is waiting
               if (w_nonempty) begin
                  w_pop        = 1'b1;
                  w_state_next = S_START;
                  w_tx_next    = 1'b0;
               end else begin
                  w_state_next = S_IDLE;
                  w_tx_next    = 1'b1;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
            w_cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetb) begin
         r_state    <= S_IDLE;
         r_tx       <= 1'b1;
         r_clk_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_tx      <= w_tx_next;
         r_clk_cnt <= w_cnt_next;
         r_bit_cnt <= w_bit_next;
         if (w_pop) begin
            r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_head;
`endif
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end else if (w_shift_adv) begin
            r_shift <= {1'b0, r_shift[7:1]};
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         r_overflow <= r_overflow | (wr_valid & ~wr_ready);
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4); a line monitor
// captures whole frames cycle by cycle and records the cycle each start bit appears.
module tb_uart_tx_fifo;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   logic       clock = 1'b0;
   logic       resetb = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready, tx, busy, overflow;
   logic [2:0] level;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic [63:0] fr_q[$];
   int          st_q[$];
   int          c0;

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clock(clock), .resetb(resetb), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .tx(tx), .busy(busy), .level(level), .overflow(overflow)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1);
   end

   // line monitor: samples 1 time unit after each edge
   initial begin
      logic        mon_on;
      int          mon_idx, mon_st;
      logic [63:0] mon_vec;
      mon_on = 1'b0; mon_idx = 0; mon_st = 0; mon_vec = '0;
      forever begin
         @(posedge clock); #1;
         cyc++;
         if (resetb !== 1'b1) begin
            mon_on = 1'b0;
         end else if (!mon_on) begin
            if (tx === 1'b0) begin
               mon_on = 1'b1; mon_idx = 1; mon_vec = '0; mon_st = cyc;
            end
         end else begin
            mon_vec[mon_idx] = tx;
            mon_idx++;
            if (mon_idx == FRAME) begin
               fr_q.push_back(mon_vec);
               st_q.push_back(mon_st);
               mon_on = 1'b0;
               $display("rx frame start_cycle=%0d bits=%h", mon_st, mon_vec);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock); #2;
   endtask

   task automatic wr(input logic [7:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
      $display("write 0x%02h at cycle %0d level=%0d", d, cyc, level);
   endtask

   task automatic wait_frames(input int n);
      int budget;
      budget = n * FRAME + 20;
      while (fr_q.size() < n && budget > 0) begin
         tick();
         budget--;
      end
      chk("frame_count", 64'(fr_q.size()), 64'(n));
   endtask

   function automatic logic [63:0] pat(input logic [7:0] d);
      logic [63:0] v;
      int b;
      v = '0;
      for (int i = 0; i < FRAME; i++) begin
         b = i / CPB;
         if (b == 0)                v[i] = 1'b0;
         else if (b <= 8)           v[i] = d[b-1];
         else if (NB == 11 && b == 9) v[i] = ^d;
         else                       v[i] = 1'b1;
      end
      return v;
   endfunction

   task automatic clear_q();
      fr_q.delete();
      st_q.delete();
   endtask

   initial begin
      // reset with a write held high: must be ignored
      wr_valid = 1'b1; wr_data = 8'h5A;
      repeat (3) tick();
      chk("rst_tx", 64'(tx), 64'(1));
      chk("rst_level", 64'(level), 64'(0));
      chk("rst_wr_ready", 64'(wr_ready), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
      wr_valid = 1'b0; resetb = 1'b1;
      tick();
      chk("post_rst_level", 64'(level), 64'(0));
      clear_q();

      // single byte 0x55
      wr(8'h55);
      c0 = cyc;
      chk("single_tx_hold", 64'(tx), 64'(1));
      chk("single_level", 64'(level), 64'(1));
      chk("single_busy", 64'(busy), 64'(1));
      wait_frames(1);
      if (fr_q.size() >= 1) begin
         chk("single_start", 64'(st_q[0]), 64'(c0 + 1));
         chk("single_bits", fr_q[0], pat(8'h55));
      end
      tick();
      chk("single_idle_tx", 64'(tx), 64'(1));
      chk("single_idle_busy", 64'(busy), 64'(0));
      clear_q();

      // back-to-back 0x01, 0x02
      wr(8'h01);
      c0 = cyc;
      wr(8'h02);
      chk("b2b_level", 64'(level), 64'(1));
      wait_frames(2);
      if (fr_q.size() >= 2) begin
         chk("b2b_start0", 64'(st_q[0]), 64'(c0 + 1));
         chk("b2b_start1", 64'(st_q[1]), 64'(c0 + 1 + FRAME));
         chk("b2b_bits0", fr_q[0], pat(8'h01));
         chk("b2b_bits1", fr_q[1], pat(8'h02));
      end
      tick();
      chk("b2b_busy", 64'(busy), 64'(0));
      clear_q();

      // fill and overflow: 0xA0..0xA5
      wr(8'hA0);
      c0 = cyc;
      for (int k = 1; k < 6; k++) wr(8'hA0 + 8'(k));
      chk("ovf_level", 64'(level), 64'(4));
      chk("ovf_wr_ready", 64'(wr_ready), 64'(0));
      chk("ovf_flag", 64'(overflow), 64'(1));
      wait_frames(5);
      for (int k = 0; k < 5 && k < fr_q.size(); k++) begin
         chk($sformatf("ovf_bits%0d", k), fr_q[k], pat(8'hA0 + 8'(k)));
         chk($sformatf("ovf_start%0d", k), 64'(st_q[k]), 64'(c0 + 1 + k * FRAME));
      end
      repeat (8) tick();
      chk("ovf_no_extra", 64'(fr_q.size()), 64'(5));
      chk("ovf_sticky", 64'(overflow), 64'(1));
      chk("ovf_busy", 64'(busy), 64'(0));
      clear_q();

      // push coinciding with the STOP-to-START pop at level 2
      wr(8'hB0);
      c0 = cyc;
      wr(8'hB1);
      wr(8'hB2);
      chk("sim_level_pre", 64'(level), 64'(2));
      while (cyc < c0 + FRAME) tick();
      wr(8'hB3);
      chk("sim_level", 64'(level), 64'(2));
      wait_frames(4);
      for (int k = 0; k < 4 && k < fr_q.size(); k++) begin
         chk($sformatf("sim_bits%0d", k), fr_q[k], pat(8'hB0 + 8'(k)));
         chk($sformatf("sim_start%0d", k), 64'(st_q[k]), 64'(c0 + 1 + k * FRAME));
      end
      tick();
      clear_q();

      // reset during DATA bit 3 of 0xFF with another byte queued
      wr(8'hFF);
      c0 = cyc;
      wr(8'h11);
      while (cyc < c0 + 1 + CPB + 3 * CPB) tick();
      chk("mid_bit3", 64'(tx), 64'(1));
      chk("mid_busy", 64'(busy), 64'(1));
      resetb = 1'b0; wr_valid = 1'b1; wr_data = 8'h99;
      tick();
      chk("mid_rst_tx", 64'(tx), 64'(1));
      chk("mid_rst_level", 64'(level), 64'(0));
      chk("mid_rst_overflow", 64'(overflow), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      tick();
      chk("mid_rst_wr_ignored", 64'(level), 64'(0));
      resetb = 1'b1; wr_valid = 1'b0;
      tick();
      clear_q();
      wr(8'h3C);
      c0 = cyc;
      wait_frames(1);
      if (fr_q.size() >= 1) begin
         chk("after_rst_start", 64'(st_q[0]), 64'(c0 + 1));
         chk("after_rst_bits", fr_q[0], pat(8'h3C));
      end
      repeat (10) tick();
      chk("after_rst_only_one", 64'(fr_q.size()), 64'(1));
      clear_q();

`ifdef UART_TX_PARITY_EN
      wr(8'h07);
      c0 = cyc;
      wr(8'h03);
      wait_frames(2);
      if (fr_q.size() >= 2) begin
         chk("par_bit_07", 64'(fr_q[0][9*CPB]), 64'(1));
         chk("par_bit_03", 64'(fr_q[1][9*CPB]), 64'(0));
         chk("par_bits0", fr_q[0], pat(8'h07));
         chk("par_bits1", fr_q[1], pat(8'h03));
         chk("par_len", 64'(st_q[1] - st_q[0]), 64'(44));
      end
      tick();
      clear_q();
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
